// File: rtl/multicycle_control_unit_pkg.sv
// Shared definitions for the multi-cycle CPU control path: opcodes, the
// sequencer state encoding and the datapath mux / ALU control encodings.
package multicycle_control_unit_pkg;

   // Sequencer states; the encoding is visible on the State debug port.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5,
      ST_BRANCH = 3'd6
   } state_e;

   // Opcodes decoded by the control unit.
   localparam logic [3:0] OP_R   = 4'b0110;
   localparam logic [3:0] OP_I   = 4'b0001;
   localparam logic [3:0] OP_LS  = 4'b0010;
   localparam logic [3:0] OP_SS  = 4'b0011;
   localparam logic [3:0] OP_BEQ = 4'b0100;

   // ALU operation select.
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   // ALU B-operand select.
   localparam logic [1:0] SRCB_RT   = 2'b00;
   localparam logic [1:0] SRCB_ONE  = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;
   localparam logic [1:0] SRCB_BOFF = 2'b11;

   // PC source select.
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;

endpackage

// File: rtl/multicycle_control_unit_timer.sv
// Memory wait timer: counts consecutive not-ready cycles of a memory access
// and flags a timeout when the count reaches TIMEOUT_CYCLES with the memory
// still not ready. TIMEOUT_CYCLES = 0 disables the timeout.
module mem_wait_timer #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic wait_i,     // an access is outstanding this cycle
   input  logic ready_i,    // memory completes the access this cycle
   input  logic clear_i,    // owner is changing state
   output logic timeout_o   // one-cycle timeout pulse
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] count_q, count_d;

   // Next count: clear on completion, idle or state change; else saturating increment.
   always_comb begin
      count_d = count_q;
      if (clear_i || !wait_i || ready_i) begin
         count_d = '0;
      end else if (count_q != '1) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         // NOTE: state registers use non-blocking assignments so every flop
         // samples pre-edge values, independent of block evaluation order.
         count_q <= count_d;
      end
   end

   assign timeout_o = (TIMEOUT_CYCLES != 0) && wait_i && !ready_i && (count_q == LIMIT);

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control unit: sequences each instruction through
// FETCH/DECODE/EXEC/MEM/WB (or BRANCH) over a shared datapath with a single
// memory port, handling memory wait states, illegal opcodes and bus timeouts.
module multicycle_control_unit
   import multicycle_control_unit_pkg::*;
#(
   parameter int OPCODE_W       = 4,
   parameter int ALUOP_W        = 2,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                Enable,
   input  logic [OPCODE_W-1:0] OPCODE,
   input  logic                MemReady,
   output logic                IorD,
   output logic                MemRead,
   output logic                MemWrite,
   output logic                IRWrite,
   output logic                PCWrite,
   output logic                PCWriteCond,
   output logic [1:0]          PCSource,
   output logic                ALUSrcA,
   output logic [1:0]          ALUSrcB,
   output logic [ALUOP_W-1:0]  ALUOp,
   output logic                RegDst,
   output logic                MemToReg,
   output logic                RegWrite,
   output logic                Illegal,
   output logic                BusError,
   output logic                InstrDone,
   output logic [2:0]          State
);

   state_e              state_q, state_d;
   logic [OPCODE_W-1:0] opcode_q;
   logic                timeout;
   logic                mem_wait;
   logic [1:0]          alu_op;

   // Opcode is captured in DECODE; later states steer from the captured copy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         opcode_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == ST_DECODE) begin
            opcode_q <= OPCODE;
         end
      end
   end

   // Next-state and control-output decode from the registered state.
   always_comb begin
      // NOTE: every signal gets a default first so no path through the case
      // leaves one unassigned, which would otherwise infer a latch.
      state_d     = state_q;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      PCSource    = PCSRC_ALU;
      ALUSrcA     = 1'b0;
      ALUSrcB     = SRCB_RT;
      alu_op      = ALUOP_ADD;
      RegDst      = 1'b0;
      MemToReg    = 1'b0;
      RegWrite    = 1'b0;
      Illegal     = 1'b0;
      BusError    = 1'b0;
      InstrDone   = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (Enable) state_d = ST_FETCH;
         end

         ST_FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = SRCB_ONE;
            if (MemReady) begin
               IRWrite = 1'b1;
               PCWrite = 1'b1;
               state_d = ST_DECODE;
            end else if (timeout) begin
               MemRead  = 1'b0;
               BusError = 1'b1;
               state_d  = ST_IDLE;
            end
         end

         ST_DECODE: begin
            ALUSrcB = SRCB_BOFF;
            if (OPCODE == OPCODE_W'(OP_R) || OPCODE == OPCODE_W'(OP_I) ||
                OPCODE == OPCODE_W'(OP_LS) || OPCODE == OPCODE_W'(OP_SS)) begin
               state_d = ST_EXEC;
            end else if (OPCODE == OPCODE_W'(OP_BEQ)) begin
               state_d = ST_BRANCH;
            end else begin
               // PC already advanced in FETCH, so just move on.
               Illegal = 1'b1;
               state_d = Enable ? ST_FETCH : ST_IDLE;
            end
         end

         ST_EXEC: begin
            ALUSrcA = 1'b1;
            if (opcode_q == OPCODE_W'(OP_R)) begin
               ALUSrcB = SRCB_RT;
               alu_op  = ALUOP_FUNCT;
               state_d = ST_WB;
            end else if (opcode_q == OPCODE_W'(OP_I)) begin
               ALUSrcB = SRCB_IMM;
               state_d = ST_WB;
            end else begin
               ALUSrcB = SRCB_IMM;
               state_d = ST_MEM;
            end
         end

         ST_MEM: begin
            IorD = 1'b1;
            if (opcode_q == OPCODE_W'(OP_LS)) MemRead  = 1'b1;
            else                              MemWrite = 1'b1;
            if (MemReady) begin
               if (opcode_q == OPCODE_W'(OP_LS)) begin
                  state_d = ST_WB;
               end else begin
                  InstrDone = 1'b1;
                  state_d   = Enable ? ST_FETCH : ST_IDLE;
               end
            end else if (timeout) begin
               MemRead  = 1'b0;
               MemWrite = 1'b0;
               BusError = 1'b1;
               state_d  = ST_IDLE;
            end
         end

         ST_WB: begin
            RegWrite  = 1'b1;
            RegDst    = (opcode_q == OPCODE_W'(OP_R));
            MemToReg  = (opcode_q == OPCODE_W'(OP_LS));
            InstrDone = 1'b1;
            state_d   = Enable ? ST_FETCH : ST_IDLE;
         end

         ST_BRANCH: begin
            ALUSrcA     = 1'b1;
            ALUSrcB     = SRCB_RT;
            alu_op      = ALUOP_SUB;
            PCWriteCond = 1'b1;
            PCSource    = PCSRC_ALUOUT;
            InstrDone   = 1'b1;
            state_d     = Enable ? ST_FETCH : ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   assign mem_wait = (state_q == ST_FETCH) || (state_q == ST_MEM);
   assign ALUOp    = ALUOP_W'(alu_op);
   assign State    = state_q;

   mem_wait_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .wait_i   (mem_wait),
      .ready_i  (MemReady),
      .clear_i  (state_d != state_q),
      .timeout_o(timeout)
   );

endmodule
